// File: rtl/hamming_pkg.sv
// Shared constants, output FSM states and the decoder check-matrix
// columns for the Hamming decode scheduler.
package hamming_pkg;
  localparam int CODE_W   = 7;
  localparam int RES_W    = 8;
  localparam int FLAG_BIT = 7;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostate_e;

  // Odd-weight columns: any double error yields an even syndrome.
  function automatic logic [3:0] col_h(input int i);
    logic [3:0] c;
    unique case (i)
      0: c = 4'b0001;
      1: c = 4'b0010;
      2: c = 4'b0100;
      3: c = 4'b1000;
      4: c = 4'b0111;
      5: c = 4'b1011;
      6: c = 4'b1101;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/hamming_decoder.sv
// Combinational SEC-DED decoder, 7-bit codeword to {flag, code}.
// Inverted polarity: the check equations apply to ~code.
module hamming_decoder
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [RES_W-1:0]  o_res
);
  logic [CODE_W-1:0] w_x;
  logic [CODE_W-1:0] w_flip;
  logic [3:0]        w_syn;
  logic              w_hit;
  logic              w_unc;

  assign w_x = i_code ^ {CODE_W{1'b1}};

  always_comb begin
    w_syn = 4'b0000;
    for (int i = 0; i < CODE_W; i++) begin
      if (w_x[i]) w_syn = w_syn ^ col_h(i);
    end
  end

  always_comb begin
    w_flip = '0;
    w_hit  = 1'b0;
    for (int i = 0; i < CODE_W; i++) begin
      if (w_syn != 4'b0000 && col_h(i) == w_syn) begin
        w_flip[i] = 1'b1;
        w_hit     = 1'b1;
      end
    end
  end

  assign w_unc = (w_syn != 4'b0000) & ~w_hit;
  assign o_res = w_unc ? {1'b1, i_code}
                       : {1'b0, i_code ^ w_flip};
endmodule

// File: rtl/hamming_rr_arb.sv
// Two-way grant: round-robin (ARB_MODE=0) or req0 priority (1).
module hamming_rr_arb #(
  parameter int ARB_MODE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_v0,
  input  logic i_v1,
  input  logic i_accept,
  output logic o_grant
);
  logic r_last;
  logic w_both;

  assign w_both = i_v0 & i_v1;

  always_comb begin
    o_grant = i_v1;
    if (w_both) begin
      o_grant = (ARB_MODE == 1) ? 1'b0 : ~r_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_last <= 1'b1;
    else if (i_accept) r_last <= o_grant;
  end
endmodule

// File: rtl/hamming_decode_scheduler.sv
// Shares one hamming_decoder between two requesters; registered output.
// Error counters are built only with HAMMING_ERR_STATS_EN defined.
module hamming_decode_scheduler
  import hamming_pkg::*;
#(
  parameter int ARB_MODE = 0,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [CODE_W-1:0] req0_code,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [CODE_W-1:0] req1_code,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [RES_W-1:0]  out_data,
  output logic              out_src,
  input  logic              out_ready,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  dbl_cnt
);
  ostate_e           r_state;
  logic [RES_W-1:0]  r_data;
  logic              r_src;
  logic              w_load;
  logic              w_acc;
  logic              w_grant;
  logic [CODE_W-1:0] w_code;
  logic [RES_W-1:0]  w_dec;
  logic              w_unc;
  logic              w_cor;

  assign out_valid  = (r_state == FULL);
  assign out_data   = r_data;
  assign out_src    = r_src;
  assign w_load     = ~out_valid | out_ready;
  assign w_acc      = w_load & (req0_valid | req1_valid);
  assign req0_ready = w_load & req0_valid & ~w_grant;
  assign req1_ready = w_load & req1_valid & w_grant;
  assign w_code     = w_grant ? req1_code : req0_code;

  hamming_rr_arb #(.ARB_MODE(ARB_MODE)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_v0     (req0_valid),
    .i_v1     (req1_valid),
    .i_accept (w_acc),
    .o_grant  (w_grant)
  );

  hamming_decoder u_dec (
    .i_code (w_code),
    .o_res  (w_dec)
  );

  assign w_unc = w_dec[FLAG_BIT];
  assign w_cor = ~w_dec[FLAG_BIT] &
                 (w_dec[CODE_W-1:0] != w_code);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else if (w_acc) begin
      r_state <= FULL;
    end else if (out_ready) begin
      r_state <= EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_src  <= 1'b0;
    end else if (w_acc) begin
      r_data <= w_dec;
      r_src  <= w_grant;
    end
  end

`ifdef HAMMING_ERR_STATS_EN
  logic [CNT_W-1:0] r_corr;
  logic [CNT_W-1:0] r_dbl;

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_corr <= '0;
      r_dbl  <= '0;
    end else if (w_acc) begin
      if (w_cor && r_corr != {CNT_W{1'b1}})
        r_corr <= r_corr + 1'b1;
      if (w_unc && r_dbl != {CNT_W{1'b1}})
        r_dbl <= r_dbl + 1'b1;
    end
  end

  assign corr_cnt = r_corr;
  assign dbl_cnt  = r_dbl;
`else
  logic w_unused;
  assign w_unused = ^{clr_cnt, w_unc, w_cor};
  assign corr_cnt = '0;
  assign dbl_cnt  = '0;
`endif
endmodule

// File: tb/tb_hamming_decode_scheduler.sv
// Directed bench for hamming_decode_scheduler: three parameter sets
// share one stimulus; counter expectations follow HAMMING_ERR_STATS_EN.
module tb_hamming_decode_scheduler;
`ifdef HAMMING_ERR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1, ordy, clr;
  logic [6:0] c0, c1;

  logic       a_r0, a_r1, a_ov, a_src;
  logic [7:0] a_d, a_corr, a_dbl;
  logic       b_r0, b_r1, b_ov, b_src;
  logic [7:0] b_d, b_corr, b_dbl;
  logic       s_r0, s_r1, s_ov, s_src;
  logic [7:0] s_d;
  logic [1:0] s_corr, s_dbl;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  hamming_decode_scheduler #(.ARB_MODE(0), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_code(c0), .req0_ready(a_r0),
    .req1_valid(v1), .req1_code(c1), .req1_ready(a_r1),
    .out_valid(a_ov), .out_data(a_d), .out_src(a_src),
    .out_ready(ordy), .clr_cnt(clr),
    .corr_cnt(a_corr), .dbl_cnt(a_dbl)
  );

  hamming_decode_scheduler #(.ARB_MODE(1), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_code(c0), .req0_ready(b_r0),
    .req1_valid(v1), .req1_code(c1), .req1_ready(b_r1),
    .out_valid(b_ov), .out_data(b_d), .out_src(b_src),
    .out_ready(ordy), .clr_cnt(clr),
    .corr_cnt(b_corr), .dbl_cnt(b_dbl)
  );

  hamming_decode_scheduler #(.ARB_MODE(0), .CNT_W(2)) u_s (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_code(c0), .req0_ready(s_r0),
    .req1_valid(v1), .req1_code(c1), .req1_ready(s_r1),
    .out_valid(s_ov), .out_data(s_d), .out_src(s_src),
    .out_ready(ordy), .clr_cnt(clr),
    .corr_cnt(s_corr), .dbl_cnt(s_dbl)
  );

  typedef struct {
    logic       v0;
    logic [6:0] c0;
    logic       v1;
    logic [6:0] c1;
    logic       ordy;
    logic       r0;
    logic       r1;
    logic       ov;
    logic [7:0] d;
    logic       src;
    int         corr;
    int         dbl;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string n, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               n, act, exp);
    end
  endtask

  function automatic int sx(input int v);
    return STATS ? v : 0;
  endfunction

  task automatic drive(input logic iv0, input logic [6:0] ic0,
                       input logic iv1, input logic [6:0] ic1,
                       input logic ior, input logic iclr);
    v0 = iv0; c0 = ic0; v1 = iv1; c1 = ic1;
    ordy = ior; clr = iclr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 7'h00, 0, 7'h00, 1, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1, 7'h7F, 0, 7'h00, 1, 1, 0, 1, 8'h7F, 0, 0, 0};
    tbl[1]  = '{0, 7'h00, 1, 7'h3F, 1, 0, 1, 1, 8'h7F, 1, 1, 0};
    tbl[2]  = '{1, 7'h40, 0, 7'h00, 1, 1, 0, 1, 8'hC0, 0, 1, 1};
    tbl[3]  = '{1, 7'h7F, 1, 7'h3F, 1, 0, 1, 1, 8'h7F, 1, 2, 1};
    tbl[4]  = '{1, 7'h7F, 1, 7'h3F, 1, 1, 0, 1, 8'h7F, 0, 2, 1};
    tbl[5]  = '{1, 7'h7F, 1, 7'h3F, 1, 0, 1, 1, 8'h7F, 1, 3, 1};
    tbl[6]  = '{1, 7'h7F, 1, 7'h3F, 1, 1, 0, 1, 8'h7F, 0, 3, 1};
    tbl[7]  = '{1, 7'h7F, 1, 7'h40, 0, 0, 0, 1, 8'h7F, 0, 3, 1};
    tbl[8]  = '{1, 7'h7F, 1, 7'h40, 0, 0, 0, 1, 8'h7F, 0, 3, 1};
    tbl[9]  = '{1, 7'h7F, 1, 7'h40, 0, 0, 0, 1, 8'h7F, 0, 3, 1};
    tbl[10] = '{1, 7'h7F, 1, 7'h40, 1, 0, 1, 1, 8'hC0, 1, 3, 2};
    tbl[11] = '{0, 7'h00, 0, 7'h00, 1, 0, 0, 0, 8'hC0, 1, 3, 2};
    tbl[12] = '{0, 7'h00, 0, 7'h00, 0, 0, 0, 0, 8'hC0, 1, 3, 2};
    tbl[13] = '{1, 7'h3F, 0, 7'h00, 0, 1, 0, 1, 8'h7F, 0, 4, 2};
    tbl[14] = '{0, 7'h00, 0, 7'h00, 1, 0, 0, 0, 8'h7F, 0, 4, 2};

    do_reset();
    chk("rst_ov", a_ov, 0);
    chk("rst_data", a_d, 8'h00);
    chk("rst_src", a_src, 0);
    chk("rst_corr", a_corr, 0);
    chk("rst_dbl", a_dbl, 0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v0, tbl[i].c0, tbl[i].v1, tbl[i].c1,
            tbl[i].ordy, 0);
      @(negedge clk);
      chk($sformatf("v%0d_r0", i), a_r0, tbl[i].r0);
      chk($sformatf("v%0d_r1", i), a_r1, tbl[i].r1);
      tick();
      chk($sformatf("v%0d_ov", i), a_ov, tbl[i].ov);
      chk($sformatf("v%0d_data", i), a_d, tbl[i].d);
      chk($sformatf("v%0d_src", i), a_src, tbl[i].src);
      chk($sformatf("v%0d_corr", i), a_corr, sx(tbl[i].corr));
      chk($sformatf("v%0d_dbl", i), a_dbl, sx(tbl[i].dbl));
    end

    // both requesters valid from a fresh reset
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1, 7'h7F, 1, 7'h3F, 1, 0);
      @(negedge clk);
      chk($sformatf("fix%0d_r1", k), b_r1, 0);
      chk($sformatf("fix%0d_r0", k), b_r0, 1);
      tick();
      chk($sformatf("rr%0d_src", k), a_src, k % 2);
      chk($sformatf("fix%0d_src", k), b_src, 0);
    end

    // saturation at CNT_W=2, then clear beating an increment
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      drive(1, 7'h3F, 0, 7'h00, 1, 0);
      tick();
      chk($sformatf("sat%0d_corr", k), s_corr,
          sx(k > 3 ? 3 : k));
      chk($sformatf("wide%0d_corr", k), a_corr, sx(k));
    end
    drive(1, 7'h3F, 0, 7'h00, 1, 1);
    tick();
    chk("clr_s_corr", s_corr, 0);
    chk("clr_a_corr", a_corr, 0);
    chk("clr_ov", s_ov, 1);
    drive(1, 7'h3F, 0, 7'h00, 1, 0);
    tick();
    chk("post_clr_corr", s_corr, sx(1));

    // reset while FULL and stalled
    drive(0, 7'h00, 0, 7'h00, 0, 0);
    tick();
    chk("pre_rst_full", a_ov, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ov", a_ov, 0);
    chk("mid_rst_data", a_d, 8'h00);
    chk("mid_rst_corr", a_corr, 0);
    chk("mid_rst_scorr", s_corr, 0);
    drive(0, 7'h00, 0, 7'h00, 1, 0);
    tick();
    chk("idle1_ov", a_ov, 0);
    tick();
    chk("idle2_ov", a_ov, 0);
    drive(1, 7'h7F, 1, 7'h40, 1, 0);
    @(negedge clk);
    chk("lg_r0", a_r0, 1);
    chk("lg_r1", a_r1, 0);
    tick();
    chk("lg_src", a_src, 0);
    chk("lg_data", a_d, 8'h7F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
